// File: rtl/fp_divider_param.sv
// fp_divider_param: parameterised IEEE-754-style floating-point divider.
//
// One operation at a time, strobe/busy handshake on both sides. Restoring division producing one
// quotient bit per cycle, followed by normalisation, subnormal denormalisation, rounding and
// packing. Produces IEEE exception flags.
//
// Parameters:
//   EXP_W  exponent field width (4..11)
//   MAN_W  stored fraction width (3..52); word width is 1+EXP_W+MAN_W
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_rmode   rounding mode, only with FP_DIV_RMODE_EN
//              (00 RNE, 01 RTZ, 10 toward -inf, 11 toward +inf)
//   in_a/in_b  dividend / divisor
//   in_stb     operands valid
//   in_busy    operation in flight, operands ignored
//   out_z      quotient
//   out_flags  {invalid, div_by_zero, overflow, underflow, inexact}
//   out_stb    result valid
//   out_busy   downstream not ready
//
// Optional feature: define FP_DIV_RMODE_EN to add in_rmode; otherwise round-to-nearest-even only.

module fp_divider_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FP_DIV_RMODE_EN
  input  logic [1:0]           in_rmode,
`endif
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_stb,
  output logic                 in_busy,
  output logic [EXP_W+MAN_W:0] out_z,
  output logic [4:0]           out_flags,
  output logic                 out_stb,
  input  logic                 out_busy
);

  localparam int unsigned WordW = 1 + EXP_W + MAN_W;
  localparam int unsigned ExpW  = EXP_W + 3;
  localparam int unsigned QuoW  = MAN_W + 4;
  localparam int unsigned CntW  = $clog2(QuoW);
  localparam int          BiasI = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [ExpW-1:0] Bias    = ExpW'(BiasI);
  localparam logic signed [ExpW-1:0] EMin    = ExpW'(1 - BiasI);
  // Below this exponent more than MAN_W+2 right shifts would be needed.
  localparam logic signed [ExpW-1:0] EMinSat = ExpW'(1 - BiasI - int'(MAN_W) - 2);
  localparam logic [CntW-1:0]        CntLast = CntW'(QuoW - 1);

  typedef enum logic [3:0] {
    StIdle, StUnpack, StSpecial, StNormA, StNormB, StDivInit, StDiv, StNorm, StDenorm,
    StRound, StPack, StOutput
  } state_t;

  state_t                  state_q;
  logic [WordW-1:0]        a_q, b_q;
`ifdef FP_DIV_RMODE_EN
  logic [1:0]              rmode_q;
`endif
  logic                    sign_q;
  logic signed [ExpW-1:0]  ea_q, eb_q, exp_q;
  logic [MAN_W:0]          ma_q, mb_q, mant_q;
  logic [MAN_W+1:0]        rem_q;
  logic [QuoW-1:0]         quo_q;
  logic [CntW-1:0]         cnt_q;
  logic                    sticky_q, inexact_q, underflow_q;

  // Operand classification
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign a_exp  = a_q[WordW-2:MAN_W];
  assign b_exp  = b_q[WordW-2:MAN_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign a_snan = a_nan & ~a_frac[MAN_W-1];
  assign b_snan = b_nan & ~b_frac[MAN_W-1];
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);
  assign a_zero = ~(|a_exp) & ~(|a_frac);
  assign b_zero = ~(|b_exp) & ~(|b_frac);

  logic [WordW-1:0] qnan_z, inf_z, zero_z, ovf_z;
  assign qnan_z = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  assign inf_z  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_z = {sign_q, {(WordW-1){1'b0}}};

  // Restoring division step
  logic             rem_ge;
  logic [MAN_W+1:0] rem_sub;
  assign rem_ge  = rem_q >= {1'b0, mb_q};
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Rounding: quotient layout is {int, frac[MAN_W], guard, round, spare}
  logic             guard, rnd, stk, lsb, inexact_c, inc;
  logic [MAN_W+1:0] mant_sum;
  logic [EXP_W-1:0] exp_field;

  always_comb begin
    guard     = quo_q[2];
    rnd       = quo_q[1];
    stk       = sticky_q | quo_q[0];
    lsb       = quo_q[3];
    inexact_c = guard | rnd | stk;
    inc       = guard & (rnd | stk | lsb);
`ifdef FP_DIV_RMODE_EN
    case (rmode_q)
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact_c & sign_q;
      2'b11:   inc = inexact_c & ~sign_q;
      default: inc = guard & (rnd | stk | lsb);
    endcase
`endif
    mant_sum  = {1'b0, quo_q[QuoW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    exp_field = EXP_W'(exp_q + Bias);
  end

  always_comb begin
    ovf_z = inf_z;
`ifdef FP_DIV_RMODE_EN
    // Directed/truncating modes saturate to max-finite when rounding away from infinity.
    if ((rmode_q == 2'b01) || ((rmode_q == 2'b10) && !sign_q) ||
        ((rmode_q == 2'b11) && sign_q)) begin
      ovf_z = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_busy   <= 1'b0;
      out_stb   <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_stb && !in_busy) begin
            a_q     <= in_a;
            b_q     <= in_b;
`ifdef FP_DIV_RMODE_EN
            rmode_q <= in_rmode;
`endif
            in_busy <= 1'b1;
            state_q <= StUnpack;
          end
        end
        StUnpack: begin
          sign_q  <= a_q[WordW-1] ^ b_q[WordW-1];
          ea_q    <= (a_exp == '0) ? EMin : ($signed({3'b000, a_exp}) - Bias);
          eb_q    <= (b_exp == '0) ? EMin : ($signed({3'b000, b_exp}) - Bias);
          ma_q    <= {|a_exp, a_frac};
          mb_q    <= {|b_exp, b_frac};
          state_q <= StSpecial;
        end
        StSpecial: begin
          state_q <= StOutput;
          if (a_nan || b_nan) begin
            out_z     <= qnan_z;
            out_flags <= {a_snan | b_snan, 4'b0000};
          end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            out_z     <= qnan_z;
            out_flags <= 5'b10000;
          end else if (a_inf) begin
            out_z     <= inf_z;
            out_flags <= 5'b00000;
          end else if (b_inf || a_zero) begin
            out_z     <= zero_z;
            out_flags <= 5'b00000;
          end else if (b_zero) begin
            out_z     <= inf_z;
            out_flags <= 5'b01000;
          end else begin
            state_q <= StNormA;
          end
        end
        StNormA: begin
          if (ma_q[MAN_W]) begin
            state_q <= StNormB;
          end else begin
            ma_q <= ma_q << 1;
            ea_q <= ea_q - 1'b1;
          end
        end
        StNormB: begin
          if (mb_q[MAN_W]) begin
            state_q <= StDivInit;
          end else begin
            mb_q <= mb_q << 1;
            eb_q <= eb_q - 1'b1;
          end
        end
        StDivInit: begin
          rem_q    <= {1'b0, ma_q};
          quo_q    <= '0;
          cnt_q    <= '0;
          exp_q    <= ea_q - eb_q;
          sticky_q <= 1'b0;
          state_q  <= StDiv;
        end
        StDiv: begin
          quo_q <= {quo_q[QuoW-2:0], rem_ge};
          rem_q <= rem_sub << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            sticky_q <= |rem_sub;
            state_q  <= StNorm;
          end
        end
        StNorm: begin
          // Quotient lies in (0.5, 2), so a single left shift is enough.
          if (!quo_q[QuoW-1] && (exp_q > EMin)) begin
            quo_q <= quo_q << 1;
            exp_q <= exp_q - 1'b1;
          end
          state_q <= StDenorm;
        end
        StDenorm: begin
          if (exp_q < EMin) begin
            if (exp_q < EMinSat) begin
              quo_q    <= '0;
              sticky_q <= 1'b1;
              exp_q    <= EMin;
            end else begin
              quo_q    <= quo_q >> 1;
              sticky_q <= sticky_q | quo_q[0];
              exp_q    <= exp_q + 1'b1;
            end
          end else begin
            state_q <= StRound;
          end
        end
        StRound: begin
          inexact_q   <= inexact_c;
          underflow_q <= ~quo_q[QuoW-1] & inexact_c;
          if (mant_sum[MAN_W+1]) begin
            mant_q <= mant_sum[MAN_W+1:1];
            exp_q  <= exp_q + 1'b1;
          end else begin
            mant_q <= mant_sum[MAN_W:0];
          end
          state_q <= StPack;
        end
        StPack: begin
          if (exp_q > Bias) begin
            out_z     <= ovf_z;
            out_flags <= {3'b001, underflow_q, 1'b1};
          end else begin
            // A clear hidden bit here can only occur at the minimum exponent: subnormal.
            out_z     <= {sign_q, mant_q[MAN_W] ? exp_field : {EXP_W{1'b0}},
                          mant_q[MAN_W-1:0]};
            out_flags <= {3'b000, underflow_q, inexact_q};
          end
          state_q <= StOutput;
        end
        StOutput: begin
          if (!out_stb) begin
            out_stb <= 1'b1;
          end else if (!out_busy) begin
            out_stb <= 1'b0;
            in_busy <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_param.sv
// tb_fp_divider_param: self-checking bench for fp_divider_param.
// Instantiates a bf16 divider (default parameters) and an fp32 divider. Directed vectors cover
// specials, overflow, subnormal results, handshake stall and reset mid-operation; random operands
// are compared against an exact-arithmetic reference model.

module tb_fp_divider_param;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [15:0] a16, b16, z16;
  logic        stb16, ibusy16, ostb16, obusy16;
  logic [4:0]  fl16;

  logic [31:0] a32, b32, z32;
  logic        stb32, ibusy32, ostb32, obusy32;
  logic [4:0]  fl32;

  fp_divider_param u_dut16 (
    .clk       (clk),
    .rst       (rst),
`ifdef FP_DIV_RMODE_EN
    .in_rmode  (2'b00),
`endif
    .in_a      (a16),
    .in_b      (b16),
    .in_stb    (stb16),
    .in_busy   (ibusy16),
    .out_z     (z16),
    .out_flags (fl16),
    .out_stb   (ostb16),
    .out_busy  (obusy16)
  );

  fp_divider_param #(
    .EXP_W (8),
    .MAN_W (23)
  ) u_dut32 (
    .clk       (clk),
    .rst       (rst),
`ifdef FP_DIV_RMODE_EN
    .in_rmode  (2'b00),
`endif
    .in_a      (a32),
    .in_b      (b32),
    .in_stb    (stb32),
    .in_busy   (ibusy32),
    .out_z     (z32),
    .out_flags (fl32),
    .out_stb   (ostb32),
    .out_busy  (obusy32)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: exact rational quotient, rounded to nearest even. Returns {flags, z}.
  function automatic logic [68:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input int ew, input int mw);
    logic [63:0] one, emask, fmask, ea, eb, fa, fb, ma, mb, num, y, hi, inf, zero, qnan, z;
    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, snan;
    logic        rem, guard, rs, tiny, inexact;
    int          bias, emin, xa, xb, e0, e, be, sh, field;
    one   = 64'd1;
    bias  = (1 << (ew - 1)) - 1;
    emin  = 1 - bias;
    emask = (one << ew) - 1;
    fmask = (one << mw) - 1;
    ea    = (a >> mw) & emask;
    eb    = (b >> mw) & emask;
    fa    = a & fmask;
    fb    = b & fmask;
    sign  = a[ew+mw] ^ b[ew+mw];
    zero  = {63'd0, sign} << (ew + mw);
    inf   = zero | (emask << mw);
    qnan  = (one << (ew + mw)) | (emask << mw) | (one << (mw - 1));
    a_nan = (ea == emask) && (fa != 0);
    b_nan = (eb == emask) && (fb != 0);
    a_inf = (ea == emask) && (fa == 0);
    b_inf = (eb == emask) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
    snan  = (a_nan && !fa[mw-1]) || (b_nan && !fb[mw-1]);
    if (a_nan || b_nan) return {snan, 4'b0000, qnan};
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {5'b10000, qnan};
    if (a_inf) return {5'b00000, inf};
    if (b_inf || a_zero) return {5'b00000, zero};
    if (b_zero) return {5'b01000, inf};
    ma = (ea != 0) ? (fa | (one << mw)) : fa;
    mb = (eb != 0) ? (fb | (one << mw)) : fb;
    xa = (ea != 0) ? (int'(ea) - bias) : emin;
    xb = (eb != 0) ? (int'(eb) - bias) : emin;
    while (ma < (one << mw)) begin ma = ma << 1; xa--; end
    while (mb < (one << mw)) begin mb = mb << 1; xb--; end
    e0 = xa - xb;
    e  = (ma >= mb) ? e0 : e0 - 1;
    be = (e < emin) ? emin : e;
    // Integer quotient scaled so that hi has MAN_W fraction bits plus guard and round below.
    sh = e0 - be + mw + 2;
    if (sh >= 0) begin
      num = ma << sh;
      y   = num / mb;
      rem = (num % mb) != 0;
    end else begin
      y   = 0;
      rem = 1'b1;
    end
    guard   = y[1];
    rs      = y[0] | rem;
    hi      = y >> 2;
    tiny    = hi < (one << mw);
    inexact = guard | rs;
    if (guard && (rs || hi[0])) hi = hi + 1;
    if (hi >= (one << (mw + 1))) begin hi = hi >> 1; be++; end
    if (be > bias) return {5'b00101, inf};
    field = (hi >= (one << mw)) ? be + bias : 0;
    z = zero | (64'(field) << mw) | (hi & fmask);
    return {3'b000, tiny & inexact, inexact, z};
  endfunction

  function automatic logic [63:0] gen_op(input int ew, input int mw);
    logic [63:0] one, emax, e, f;
    logic        s;
    one  = 64'd1;
    emax = (one << ew) - 1;
    f    = {$urandom, $urandom} & ((one << mw) - 1);
    s    = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: begin e = 0; f = 0; end
      1: begin e = emax; f = 0; end
      2: begin e = emax; if (f == 0) f = 1; end
      3: e = 0;
      4: e = emax - 64'($urandom_range(1, 4));
      5: e = 64'($urandom_range(1, 4));
      default: e = 64'($urandom_range(1, int'(emax) - 1));
    endcase
    return ({63'd0, s} << (ew + mw)) | (e << mw) | f;
  endfunction

  task automatic recover();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, output logic [15:0] z,
                       output logic [4:0] fl, output int lat);
    @(negedge clk); a16 = a; b16 = b; stb16 = 1'b1;
    @(posedge clk); #1 stb16 = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!ostb16 && lat < 300);
    z = z16; fl = fl16;
    if (!ostb16) begin
      check_eq("timeout16", 64'(ostb16), 64'd1);
      recover();
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, output logic [31:0] z,
                       output logic [4:0] fl, output int lat);
    @(negedge clk); a32 = a; b32 = b; stb32 = 1'b1;
    @(posedge clk); #1 stb32 = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!ostb32 && lat < 300);
    z = z32; fl = fl32;
    if (!ostb32) begin
      check_eq("timeout32", 64'(ostb32), 64'd1);
      recover();
    end else begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct { logic [15:0] a, b, z; logic [4:0] fl; int lat; } vec_t;
  vec_t vecs[6];

  initial begin
    logic [15:0] z;
    logic [31:0] zz;
    logic [4:0]  fl;
    logic [68:0] r;
    logic [63:0] ra, rb;
    int          lat;

    vecs[0] = '{16'h3F80, 16'h4040, 16'h3EAB, 5'b00001, 21};
    vecs[1] = '{16'h40C0, 16'h4000, 16'h4040, 5'b00000, 21};
    vecs[2] = '{16'h3F80, 16'h0000, 16'h7F80, 5'b01000, 3};
    vecs[3] = '{16'h0000, 16'h8000, 16'hFFC0, 5'b10000, 3};
    vecs[4] = '{16'h7F7F, 16'h3F00, 16'h7F80, 5'b00101, 21};
    vecs[5] = '{16'h0080, 16'h4000, 16'h0040, 5'b00000, 22};

    rst = 1'b1; a16 = '0; b16 = '0; stb16 = 1'b0; obusy16 = 1'b0;
    a32 = '0; b32 = '0; stb32 = 1'b0; obusy32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_busy", 64'(ibusy16), 64'd0);
    check_eq("rst_out_stb", 64'(ostb16), 64'd0);
    check_eq("rst_out_z", 64'(z16), 64'd0);
    check_eq("rst_flags", 64'(fl16), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors (the subnormal-result case needs one DENORM shift)
    foreach (vecs[i]) begin
      run16(vecs[i].a, vecs[i].b, z, fl, lat);
      check_eq($sformatf("dir%0d_z", i), 64'(z), 64'(vecs[i].z));
      check_eq($sformatf("dir%0d_fl", i), 64'(fl), 64'(vecs[i].fl));
      check_eq($sformatf("dir%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check_eq($sformatf("dir%0d_idle", i), 64'(ibusy16), 64'd0);
    end

    // Downstream stall: result held, new strobes ignored
    obusy16 = 1'b1;
    @(negedge clk); a16 = 16'h40C0; b16 = 16'h4000; stb16 = 1'b1;
    @(posedge clk); #1 stb16 = 1'b0;
    check_eq("hs_accept_busy", 64'(ibusy16), 64'd1);
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!ostb16 && lat < 300);
    check_eq("hs_lat", 64'(lat), 64'd21);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); a16 = 16'h3F80; b16 = 16'h4040; stb16 = 1'b1;
      @(posedge clk); #1;
      check_eq("hs_z", 64'(z16), 64'h4040);
      check_eq("hs_fl", 64'(fl16), 64'd0);
      check_eq("hs_in_busy", 64'(ibusy16), 64'd1);
      check_eq("hs_out_stb", 64'(ostb16), 64'd1);
    end
    @(negedge clk); stb16 = 1'b0; obusy16 = 1'b0;
    @(posedge clk); #1;
    check_eq("rel_in_busy", 64'(ibusy16), 64'd0);
    check_eq("rel_out_stb", 64'(ostb16), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("no_queue_busy", 64'(ibusy16), 64'd0);
    check_eq("no_queue_stb", 64'(ostb16), 64'd0);

    // Reset while dividing
    @(negedge clk); a16 = 16'h3F80; b16 = 16'h4040; stb16 = 1'b1;
    @(posedge clk); #1 stb16 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_busy", 64'(ibusy16), 64'd0);
    check_eq("mid_rst_stb", 64'(ostb16), 64'd0);
    check_eq("mid_rst_z", 64'(z16), 64'd0);
    @(negedge clk); rst = 1'b0;
    run16(16'h40C0, 16'h4000, z, fl, lat);
    check_eq("post_rst_z", 64'(z), 64'h4040);
    check_eq("post_rst_fl", 64'(fl), 64'd0);

    // Random bf16
    for (int i = 0; i < 300; i++) begin
      ra = gen_op(8, 7);
      rb = gen_op(8, 7);
      r  = ref_div(ra, rb, 8, 7);
      run16(ra[15:0], rb[15:0], z, fl, lat);
      check_eq($sformatf("rnd16 %h/%h z", ra[15:0], rb[15:0]), 64'(z), 64'(r[15:0]));
      check_eq($sformatf("rnd16 %h/%h fl", ra[15:0], rb[15:0]), 64'(fl), 64'(r[68:64]));
      if ((ra[14:7] == 8'hFF) || (rb[14:7] == 8'hFF) || (ra[14:0] == 0) || (rb[14:0] == 0))
        check_eq("rnd16_lat_special", 64'(lat), 64'd3);
      else if ((ra[14:7] != 0) && (rb[14:7] != 0) && (r[14:7] >= 8'd2))
        check_eq("rnd16_lat_normal", 64'(lat), 64'd21);
    end

    // fp32
    run32(32'h3F800000, 32'h40400000, zz, fl, lat);
    check_eq("fp32_third_z", 64'(zz), 64'h3EAAAAAB);
    check_eq("fp32_third_fl", 64'(fl), 64'd1);
    check_eq("fp32_third_lat", 64'(lat), 64'd37);
    for (int i = 0; i < 100; i++) begin
      ra = gen_op(8, 23);
      rb = gen_op(8, 23);
      r  = ref_div(ra, rb, 8, 23);
      run32(ra[31:0], rb[31:0], zz, fl, lat);
      check_eq($sformatf("rnd32 %h/%h z", ra[31:0], rb[31:0]), 64'(zz), 64'(r[31:0]));
      check_eq($sformatf("rnd32 %h/%h fl", ra[31:0], rb[31:0]), 64'(fl), 64'(r[68:64]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_divider_param.md
Name: fp_divider_param

Overview:
- Parameterised IEEE-754-style floating-point divider; next generation of the bf16 divider.
- Exponent and mantissa widths are set by parameters, so one RTL covers bf16, fp16 and fp32.
- Adds correct round-to-nearest-even, subnormal results and IEEE exception flags.
- Sits on the co-processor datapath behind the same strobe/busy handshake as the other arithmetic units.

Parameters:
EXP_W, 8, exponent field width (legal range 4..11)
MAN_W, 7, stored mantissa (fraction) width (legal range 3..52); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_a  in  W  dividend operand
in_b  in  W  divisor operand
in_stb  in  1  operands valid
in_busy  out  1  high while an operation is in flight; operands are ignored while high
out_z  out  W  quotient
out_flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}
out_stb  out  1  result valid
out_busy  in  1  downstream not ready

Behaviour:
- Reset (rst sampled high at an edge) overrides everything, including mid-operation:
  - state=IDLE; in_busy=0, out_stb=0, out_z=0, out_flags=0.
  - The in-flight operation is discarded.
- Input handshake:
  - Accept on an edge with state=IDLE, in_busy=0, in_stb=1: latch in_a/in_b; in_busy=1 from the next cycle.
  - in_busy stays 1 until the FSM returns to IDLE.
- Output handshake:
  - out_stb rises in OUTPUT; out_z and out_flags are registered and stable while out_stb=1.
  - Transfer completes on an edge with out_stb=1 and out_busy=0: out_stb->0, state->IDLE, in_busy->0 on the same edge.
  - Next accept is possible on the following edge.
- FSM: IDLE -> UNPACK -> SPECIAL -> NORM_A -> NORM_B -> DIV_INIT -> DIV -> NORM -> DENORM -> ROUND -> PACK -> OUTPUT -> IDLE.
- Special operands (SPECIAL -> OUTPUT directly):
  - Canonical NaN = sign 1, exponent all ones, fraction MSB 1, rest 0.
  - NaN operand -> canonical NaN; invalid flag set only if that NaN is signalling (fraction MSB 0).
  - inf/inf and 0/0 -> canonical NaN, invalid.
  - inf/finite -> signed inf.
  - finite/inf -> signed 0.
  - 0/nonzero -> signed 0.
  - nonzero finite/0 -> signed inf, div_by_zero.
  - Sign of all non-NaN results = sign_a XOR sign_b.
- Normalise:
  - Subnormal operands take exponent 1-bias (bias=2^(EXP_W-1)-1).
  - NORM_A and NORM_B shift left one bit per cycle until the hidden bit is set; normal operands spend exactly 1 cycle in each.
- Divide:
  - Restoring division, one quotient bit per cycle, Q_W=MAN_W+4 cycles.
  - Quotient bits are 1 integer, MAN_W fraction, guard, round and one spare.
  - sticky = OR of any discarded quotient bits | (final remainder != 0).
  - Result exponent is held signed in EXP_W+3 bits.
- NORM:
  - If the quotient integer bit is 0 and exp > 1-bias: shift left 1, exp-1.
  - Takes at most 1 cycle (quotient is in (0.5, 2)).
- DENORM:
  - While exp < 1-bias: shift right 1, exp+1, shifted-out bits fold into sticky.
  - If more than MAN_W+2 shifts are needed, saturate to zero mantissa with sticky=1.
- ROUND:
  - Round-to-nearest-even: increment when guard & (round | sticky | lsb).
  - Mantissa carry-out bumps the exponent.
  - A subnormal rounding up into the hidden bit becomes the minimum normal.
- PACK:
  - Hidden bit 0 at exp=1-bias -> exponent field 0.
  - exp > bias -> signed inf with overflow|inexact.
- Flags:
  - inexact = guard|round|sticky before rounding.
  - underflow = result subnormal or zero after DENORM AND inexact.
  - Flags are otherwise 0.
- Latency:
  - Normal operands: out_stb first high at edge MAN_W+14 after the accept edge (bf16: 21).
  - Each leading zero of a subnormal operand adds 1 cycle.
  - Each extra DENORM shift adds 1 cycle.
  - Special operands: out_stb high at edge 3.
- in_stb while busy is ignored, not queued.

Optional Feature:
- Macro FP_DIV_RMODE_EN.
- Defined:
  - Adds port in_rmode (in, 2), latched with the operands.
  - Encodings: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
  - Overflow yields inf or max-finite according to mode and sign.
- Undefined: port absent; RNE only.

Test Plan:
- bf16 0x3F80 / 0x4040 -> out_z=0x3EAB, flags=00001; out_stb at edge 21 after accept.
- 0x40C0 / 0x4000 -> 0x4040, flags=0.
- 0x3F80 / 0x0000 -> 0x7F80, flags=01000.
- 0x0000 / 0x8000 -> 0xFFC0, flags=10000; out_stb at edge 3.
- 0x7F7F / 0x3F00 -> 0x7F80, flags=00101.
- 0x0080 / 0x4000 -> 0x0040, flags=0.
- Handshake:
  - Hold out_busy=1 for 10 cycles: out_z and flags stay stable, in_busy stays 1, a second in_stb is ignored.
  - Release out_busy: IDLE, in_busy=0 on the same edge.
- Reset mid-operation: assert rst during DIV -> next cycle in_busy=0, out_stb=0; a fresh 0x40C0/0x4000 then yields 0x4040.
- fp32 build (EXP_W=8, MAN_W=23): 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, inexact.
